aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences key expansion, round-key reads and AES rounds.
// Define AES_KEY_REUSE_EN to add reuse_key and skip re-expansion of a valid key.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS  = 10,
  parameter int KEY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef AES_KEY_REUSE_EN
  input  logic       reuse_key,
`endif
  output logic       key_en,
  input  logic       key_done,
  output logic       key_rd_en,
  output logic [3:0] addr,
  output logic       rnd_start,
  output logic       rnd_first,
  output logic       rnd_last,
  input  logic       rnd_done,
  output logic [3:0] round_cnt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_EXP,
    KEY_RD,
    ROUND,
    WAIT_RND,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  localparam logic [8:0] TMO  = 9'(KEY_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] tmo_cnt, tmo_n;
  logic       key_en_n, rd_n, rs_n, rf_n, rl_n;
  logic       done_n, err_n, busy_n, tmo_hit;
  logic [3:0] addr_n, cnt_n;
  logic       reuse_ok;
  logic       cancel;

  assign cancel = abort && (state != IDLE);

`ifdef AES_KEY_REUSE_EN
  logic key_valid;

  // Remember a completed expansion so a later start may skip it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
    end else if (cancel) begin
      key_valid <= 1'b0;
    end else if (state == KEY_EXP && key_done) begin
      key_valid <= 1'b1;
    end else if (tmo_hit) begin
      key_valid <= 1'b0;
    end
  end

  assign reuse_ok = reuse_key & key_valid;
`else
  assign reuse_ok = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_n  = state;
    tmo_n    = tmo_cnt;
    key_en_n = key_en;
    rd_n     = 1'b0;
    addr_n   = 4'd0;
    rs_n     = 1'b0;
    rf_n     = 1'b0;
    rl_n     = 1'b0;
    cnt_n    = round_cnt;
    done_n   = 1'b0;
    err_n    = err;
    tmo_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n = 4'd0;
          err_n = 1'b0;
          tmo_n = 8'd0;
          if (reuse_ok) begin
            state_n = KEY_RD;
            rd_n    = 1'b1;
          end else begin
            state_n  = KEY_EXP;
            key_en_n = 1'b1;
          end
        end
      end
      KEY_EXP: begin
        if (key_done) begin
          key_en_n = 1'b0;
          state_n  = KEY_RD;
          rd_n     = 1'b1;
          addr_n   = round_cnt;
        end else if ({1'b0, tmo_cnt} + 9'd1 == TMO) begin
          tmo_hit  = 1'b1;
          err_n    = 1'b1;
          key_en_n = 1'b0;
          state_n  = IDLE;
        end else begin
          tmo_n = tmo_cnt + 8'd1;
        end
      end
      KEY_RD: begin
        state_n = ROUND;
        rs_n    = 1'b1;
        rf_n    = (round_cnt == 4'd0);
        rl_n    = (round_cnt == LAST);
      end
      ROUND: begin
        state_n = WAIT_RND;
      end
      WAIT_RND: begin
        if (rnd_done) begin
          if (round_cnt < LAST) begin
            cnt_n   = round_cnt + 4'd1;
            state_n = KEY_RD;
            rd_n    = 1'b1;
            addr_n  = round_cnt + 4'd1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (cancel) begin
      state_n  = IDLE;
      tmo_n    = tmo_cnt;
      key_en_n = 1'b0;
      rd_n     = 1'b0;
      addr_n   = 4'd0;
      rs_n     = 1'b0;
      rf_n     = 1'b0;
      rl_n     = 1'b0;
      cnt_n    = round_cnt;
      done_n   = 1'b0;
      err_n    = err;
      tmo_hit  = 1'b0;
    end
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      key_en    <= 1'b0;
      key_rd_en <= 1'b0;
      addr      <= 4'd0;
      rnd_start <= 1'b0;
      rnd_first <= 1'b0;
      rnd_last  <= 1'b0;
      round_cnt <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      tmo_cnt   <= tmo_n;
      key_en    <= key_en_n;
      key_rd_en <= rd_n;
      addr      <= addr_n;
      rnd_start <= rs_n;
      rnd_first <= rf_n;
      rnd_last  <= rl_n;
      round_cnt <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule
